ex_muldiv_unit: RTL

- Execute-stage multicycle multiply/divide unit.
- Owns the HI/LO register pair and sits directly downstream of the ALU control decoder.
- Starts an iterative signed multiply or divide when the decoder issues it, stalls the pipeline until the result is committed, and serves move-from-HI/LO reads.

---
 rtl/ex_muldiv_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ex_muldiv_unit.sv
// Execute-stage multicycle multiply/divide unit.
// Owns the HI/LO pair. It runs a WIDTH-cycle shift-add multiply or a restoring
// divide on operand magnitudes, then applies the signs in a single FIX cycle.
// Handshake: stall is the only flow-control signal. While stall is high the
// upstream stages hold the EX inputs. A mult/div is accepted in the IDLE cycle
// where start is high. Its HI/LO result is readable from the first IDLE cycle
// after FIX.
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [3:0]       ex_alu_signal,
  input  logic [1:0]       ex_alu_float,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             stall,
  output logic [WIDTH-1:0] mf_result,
  output logic             div_by_zero,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   hi, lo, a_mag, b_mag, a_abs, b_abs;
  logic [2*WIDTH-1:0] acc, acc_step, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH:0]     add_sum, trial;
  logic [CNT_W-1:0]   cnt;
  logic               op_div, res_neg, dvd_neg;
  logic               is_mult, is_div, start_req, div_zero, start;

  assign is_mult   = (ex_alu_signal == 4'b1101);
  assign is_div    = (ex_alu_signal == 4'b1010);
  assign start_req = (state == IDLE) & ex_valid & (ex_alu_float == 2'b11) & (is_mult | is_div);
  assign div_zero  = start_req & is_div & (rt_data == '0);
  assign start     = start_req & ~div_zero;
  assign stall     = start | busy;

  // The magnitude of the most-negative value wraps to its unsigned magnitude.
  assign a_abs = rs_data[WIDTH-1] ? -rs_data : rs_data;
  assign b_abs = rt_data[WIDTH-1] ? -rt_data : rt_data;

  // Next-state logic: IDLE -> CALC on start, WIDTH CALC cycles, one FIX cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration. Multiply is shift-add with the multiplier in acc's low half.
  // Divide is restoring division with the quotient shifted into acc's low half.
  always_comb begin
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
    trial   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b_mag};
    if (op_div) begin
      if (trial[WIDTH]) acc_step = {acc[2*WIDTH-2:0], 1'b0};
      else              acc_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {add_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign fix-up. The quotient takes the xor of the operand signs; the
  // remainder takes the dividend sign (truncating division).
  always_comb begin
    prod_fix = res_neg ? -acc : acc;
    quo_fix  = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = dvd_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Move-from reads are served only in IDLE, so a stale HI/LO is never returned.
  always_comb begin
    mf_result = '0;
    if (state == IDLE && ex_valid) begin
      if (ex_alu_float == 2'b01 && ex_alu_signal == 4'b1011)      mf_result = hi;
      else if (ex_alu_float == 2'b10 && ex_alu_signal == 4'b1100) mf_result = lo;
    end
  end

  // State, datapath and HI/LO registers. Reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      a_mag       <= '0;
      b_mag       <= '0;
      acc         <= '0;
      cnt         <= '0;
      op_div      <= 1'b0;
      res_neg     <= 1'b0;
      dvd_neg     <= 1'b0;
    end else begin
      state       <= state_nxt;
      busy        <= (state_nxt != IDLE);
      div_by_zero <= div_zero;
      case (state)
        IDLE: begin
          if (start) begin
            a_mag   <= a_abs;
            b_mag   <= b_abs;
            res_neg <= rs_data[WIDTH-1] ^ rt_data[WIDTH-1];
            dvd_neg <= rs_data[WIDTH-1];
            op_div  <= is_div;
            acc     <= {{WIDTH{1'b0}}, (is_div ? a_abs : b_abs)};
            cnt     <= '0;
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (op_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
